// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master slice.
package apb_pkg;
    localparam int APB_ADDR_WIDTH     = 8;
    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;
endpackage

// File: rtl/apb_master_if.sv
// Command/response and APB bus signals of the APB master, bundled as one interface.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );
endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog: counts PREADY=0 wait cycles, flags the one that reaches the limit.
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires during the wait cycle that would make the count equal TIMEOUT_CYCLES.
    assign expired = inc && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/apb_master.sv
// APB master: IDLE/SETUP/ACCESS FSM turning cmd_* requests into APB transfers.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);
    apb_state_e            state;
    apb_state_e            state_nxt;
    logic                  done;
    logic                  expired;
    logic                  cmd_ready;
    logic                  handshake;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
    logic rsp_timeout_q;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (PCLK),
        .rst    (PRESET),
        .clear  (state_nxt == SETUP),
        .inc    ((state == ACCESS) && !bus.PREADY),
        .expired(expired)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_timeout_q <= expired;
        end
    end

    assign bus.rsp_timeout = rsp_timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expired         = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    // The final ACCESS cycle accepts the next command so back-to-back transfers skip IDLE.
    assign done      = (state == ACCESS) && bus.PREADY;
    assign cmd_ready = !PRESET && ((state == IDLE) || done);
    assign handshake = bus.cmd_valid && cmd_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (done) begin
                    state_nxt = handshake ? SETUP : IDLE;
                end else if (expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= done || expired;
            rsp_err_q   <= (done && bus.PSLVERR) || expired;
            if (handshake) begin
                pwrite_q <= bus.cmd_write;
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
            end
            if (done && !pwrite_q) begin
                rdata_q <= bus.PRDATA;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.PSEL      = (state != IDLE);
    assign bus.PENABLE   = (state == ACCESS);
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master; the timeout scenario runs when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;
    logic PCLK;
    logic PRESET;
    int unsigned n_vec;
    int unsigned n_err;
    logic [31:0] exp_rdata;

    apb_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb_master #(
        .ADDR_WIDTH    (8),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Single transfer from IDLE; PREADY rises on ACCESS cycle number 'waits'.
    task automatic run_xfer(input string tag, input logic wr, input logic [7:0] addr,
                            input logic [31:0] wdata, input int unsigned waits,
                            input logic [31:0] rdata, input logic err_end, input logic err_wait);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        #1;
        chk({tag, ":idle_ready"}, 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 8'hFF;
        bus.cmd_wdata = 32'h0;
        #1;
        chk({tag, ":setup_psel"}, 32'(bus.PSEL), 32'd1);
        chk({tag, ":setup_penable"}, 32'(bus.PENABLE), 32'd0);
        chk({tag, ":setup_ready"}, 32'(bus.cmd_ready), 32'd0);
        for (int unsigned i = 0; i <= waits; i++) begin
            tick();
            bus.PREADY  = (i == waits);
            bus.PSLVERR = (i == waits) ? err_end : err_wait;
            bus.PRDATA  = (i == waits) ? rdata : (32'hBAD0_0000 | 32'(i));
            #1;
            chk({tag, ":acc_penable"}, 32'(bus.PENABLE), 32'd1);
            chk({tag, ":acc_paddr"}, 32'(bus.PADDR), 32'(addr));
            chk({tag, ":acc_pwrite"}, 32'(bus.PWRITE), 32'(wr));
            chk({tag, ":acc_pwdata"}, bus.PWDATA, wdata);
            chk({tag, ":acc_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
            chk({tag, ":acc_ready"}, 32'(bus.cmd_ready), 32'(i == waits));
        end
        tick();
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'hFFFF_FFFF;
        if (!wr) exp_rdata = rdata;
        #1;
        chk({tag, ":rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, ":rsp_err"}, 32'(bus.rsp_err), 32'(err_end));
        chk({tag, ":rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        chk({tag, ":rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
        chk({tag, ":done_psel"}, 32'(bus.PSEL), 32'd0);
        tick();
        chk({tag, ":rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    logic        b_wr    [4];
    logic [7:0]  b_addr  [4];
    logic [31:0] b_wdata [4];
    logic [31:0] b_rdata [4];

    initial begin
        n_vec         = 0;
        n_err         = 0;
        exp_rdata     = 32'h0;
        PRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h0;
        bus.cmd_wdata = 32'h0;
        bus.PRDATA    = 32'h0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        // Reset state
        repeat (3) tick();
        bus.cmd_valid = 1'b1;
        #1;
        chk("rst:cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst:psel", 32'(bus.PSEL), 32'd0);
        chk("rst:penable", 32'(bus.PENABLE), 32'd0);
        chk("rst:pwrite", 32'(bus.PWRITE), 32'd0);
        chk("rst:paddr", 32'(bus.PADDR), 32'd0);
        chk("rst:pwdata", bus.PWDATA, 32'd0);
        chk("rst:rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst:rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst:rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst:rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        bus.cmd_valid = 1'b0;
        PRESET = 1'b0;
        tick();

        run_xfer("wr_fast", 1'b1, 8'h10, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, 1'b0);
        run_xfer("rd_wait", 1'b0, 8'h20, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0);
        run_xfer("wr_slverr", 1'b1, 8'h11, 32'h0BAD_F00D, 1, 32'h0, 1'b1, 1'b0);
        run_xfer("wr_waiterr", 1'b1, 8'h12, 32'h5555_AAAA, 2, 32'h0, 1'b0, 1'b1);

        // Back-to-back: two writes then two reads, cmd_valid held throughout
        b_wr    = '{1'b1, 1'b1, 1'b0, 1'b0};
        b_addr  = '{8'h30, 8'h31, 8'h32, 8'h33};
        b_wdata = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0};
        b_rdata = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hCAFE_0001, 32'hCAFE_0002};
        bus.cmd_valid = 1'b1;
        bus.cmd_write = b_wr[0];
        bus.cmd_addr  = b_addr[0];
        bus.cmd_wdata = b_wdata[0];
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                bus.cmd_write = b_wr[k+1];
                bus.cmd_addr  = b_addr[k+1];
                bus.cmd_wdata = b_wdata[k+1];
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (k > 0 && !b_wr[k-1]) exp_rdata = b_rdata[k-1];
            #1;
            chk("b2b:setup_psel", 32'(bus.PSEL), 32'd1);
            chk("b2b:setup_penable", 32'(bus.PENABLE), 32'd0);
            chk("b2b:setup_paddr", 32'(bus.PADDR), 32'(b_addr[k]));
            chk("b2b:setup_pwrite", 32'(bus.PWRITE), 32'(b_wr[k]));
            chk("b2b:rsp_valid", 32'(bus.rsp_valid), 32'(k > 0));
            chk("b2b:rsp_rdata", bus.rsp_rdata, exp_rdata);
            tick();
            bus.PRDATA = b_rdata[k];
            #1;
            chk("b2b:acc_psel", 32'(bus.PSEL), 32'd1);
            chk("b2b:acc_penable", 32'(bus.PENABLE), 32'd1);
            chk("b2b:acc_pwdata", bus.PWDATA, b_wdata[k]);
            chk("b2b:acc_ready", 32'(bus.cmd_ready), 32'd1);
            tick();
        end
        bus.PREADY = 1'b0;
        exp_rdata  = b_rdata[3];
        #1;
        chk("b2b:end_psel", 32'(bus.PSEL), 32'd0);
        chk("b2b:end_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b:end_rsp_rdata", bus.rsp_rdata, exp_rdata);
        tick();

        // Reset sampled during ACCESS aborts the transfer
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h50;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("mid_rst:in_access", 32'(bus.PENABLE), 32'd1);
        PRESET     = 1'b1;
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h9999_9999;
        #1;
        chk("mid_rst:cmd_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        exp_rdata = 32'h0;
        chk("mid_rst:psel", 32'(bus.PSEL), 32'd0);
        chk("mid_rst:penable", 32'(bus.PENABLE), 32'd0);
        chk("mid_rst:rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst:rsp_rdata", bus.rsp_rdata, exp_rdata);
        PRESET     = 1'b0;
        bus.PREADY = 1'b0;
        tick();
        chk("mid_rst:no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst:idle", 32'(bus.PSEL), 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Watchdog: 16 unanswered ACCESS cycles force completion with error
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h40;
        bus.PREADY    = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("tmo:acc_penable", 32'(bus.PENABLE), 32'd1);
            chk("tmo:acc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        chk("tmo:idle", 32'(bus.PSEL), 32'd0);
        chk("tmo:rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("tmo:rsp_err", 32'(bus.rsp_err), 32'd1);
        chk("tmo:rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h7777_7777;
        tick();
        chk("tmo:late_ready", 32'(bus.rsp_valid), 32'd0);
        chk("tmo:late_rdata", bus.rsp_rdata, exp_rdata);
        bus.PREADY = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of PADDR and cmd_addr.
REQ-002 Parameter DATA_WIDTH, default 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum number of ACCESS wait cycles (used only with APB_MASTER_TIMEOUT_EN).
REQ-004 PCLK  input  1  single clock; all logic is on the rising edge.
REQ-005 PRESET  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  a command is offered.
REQ-007 cmd_ready  output  1  the command is accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 PSEL, PENABLE, PWRITE  output  1 each  APB control signals.
REQ-012 PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH.
REQ-013 PRDATA  input  DATA_WIDTH; PREADY  input  1; PSLVERR  input  1.
REQ-014 rsp_valid  output  1  one-cycle completion pulse.
REQ-015 rsp_rdata  output  DATA_WIDTH; rsp_err  output  1; rsp_timeout  output  1.

Function
REQ-016 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-017 IDLE: PSEL=0, PENABLE=0, cmd_ready=1; on handshake, latch write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
REQ-018 SETUP: PSEL=1, PENABLE=0, cmd_ready=0; unconditionally go to ACCESS after one cycle.
REQ-019 ACCESS: PSEL=1, PENABLE=1; stay in ACCESS while PREADY=0.
REQ-020 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP through the final ACCESS cycle.
REQ-021 ACCESS exit with PREADY=1: cmd_ready=1 combinationally that cycle; a new handshake goes to SETUP (no IDLE bubble), otherwise go to IDLE.
REQ-022 Back-to-back transfers SHALL drop PENABLE for exactly one SETUP cycle while keeping PSEL high.
REQ-023 Completion: in the cycle after the PREADY=1 sample, rsp_valid=1 for one cycle, with rsp_err equal to the sampled PSLVERR.
REQ-024 On read completion, rsp_rdata SHALL hold the sampled PRDATA; it is held until the next completion. On write completion it is unchanged.
REQ-025 PSLVERR and PRDATA SHALL be ignored unless PSEL, PENABLE and PREADY are all high.
REQ-026 Minimum transfer latency SHALL be 2 APB cycles (SETUP plus ACCESS), with rsp_valid arriving 3 cycles after the handshake.

Reset
REQ-027 While PRESET=1: state=IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout are 0; PADDR, PWDATA and rsp_rdata are 0; the timeout counter is 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer without generating rsp_valid; PSEL is 0 in the cycle after reset is sampled.
REQ-029 cmd_ready SHALL be 0 while PRESET=1.

Configuration
REQ-030 Macro APB_MASTER_TIMEOUT_EN defined: a counter increments on each ACCESS cycle with PREADY=0 and clears on entering SETUP.
REQ-031 With the macro defined, reaching TIMEOUT_CYCLES SHALL force the FSM to IDLE and issue rsp_valid with rsp_err=1 and rsp_timeout=1; a later PREADY is ignored.
REQ-032 Macro not defined: no counter is built, rsp_timeout is tied to 0, and ACCESS waits indefinitely.

Structure
REQ-033 Package apb_pkg SHALL hold the state enum apb_state_e (IDLE, SETUP, ACCESS) and the default width constants.
REQ-034 Sub-module apb_timeout_cnt SHALL implement the watchdog; it is instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-035 Write addr 0x10 data 0xA5A5A5A5 with PREADY held 1: SETUP then ACCESS (2 cycles), then rsp_valid with rsp_err=0.
REQ-036 Read addr 0x20 with PREADY low for 3 ACCESS cycles and PRDATA=0x12345678 at PREADY: exactly 4 ACCESS cycles, then rsp_rdata=0x12345678.
REQ-037 Two writes then two reads back-to-back with cmd_valid held: PSEL never drops and PENABLE is low exactly one cycle between transfers.
REQ-038 PSLVERR=1 with PREADY on a write, and PSLVERR=1 with PREADY=0 in an earlier wait cycle: only the former gives rsp_err=1.
REQ-039 PRESET asserted during ACCESS: the next cycle has PSEL=0 and PENABLE=0, and no rsp_valid is issued.
REQ-040 With APB_MASTER_TIMEOUT_EN defined and PREADY held 0: after 16 wait cycles, rsp_timeout=1, rsp_err=1 and the FSM is in IDLE.
